// File: rtl/gain_ramp_stage_if.sv
// Stream and control bundle for gain_ramp_stage.
interface gain_ramp_stage_if #(
  parameter int G_INTEGER_BITS = 16,
  parameter int G_DECIMAL_BITS = 16,
  parameter int G_DWIDTH       = 24,
  parameter int G_CHANNELS     = 2
);
  localparam int GW = G_INTEGER_BITS + G_DECIMAL_BITS;
  localparam int CW = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1;

  logic                       enable;
  logic [GW-1:0]              target_gain;
  logic [GW-1:0]              gain_step;
  logic                       clip_clear;
  logic signed [G_DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_ready;
  logic signed [G_DWIDTH-1:0] dout;
  logic [CW-1:0]              dout_chan;
  logic                       dout_last;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [GW-1:0]              cur_gain;
  logic                       clip;

  modport master (
    output enable, target_gain, gain_step, clip_clear, din, din_valid, dout_ready,
    input  din_ready, dout, dout_chan, dout_last, dout_valid, cur_gain, clip
  );

  modport slave (
    input  enable, target_gain, gain_step, clip_clear, din, din_valid, dout_ready,
    output din_ready, dout, dout_chan, dout_last, dout_valid, cur_gain, clip
  );
endinterface

// File: rtl/gain_ramp_stage.sv
// Multi-channel fixed-point gain stage with per-frame gain ramping,
// selectable rounding and a sticky clip flag. Three registered stages.
module gain_ramp_stage #(
  parameter int G_INTEGER_BITS = 16,
  parameter int G_DECIMAL_BITS = 16,
  parameter int G_DWIDTH       = 24,
  parameter int G_CHANNELS     = 2,
  parameter int G_ROUND        = 1
) (
  input logic              clk,
  input logic              reset,
  gain_ramp_stage_if.slave bus
);
  localparam int GW     = G_INTEGER_BITS + G_DECIMAL_BITS;
  localparam int CW     = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1;
  localparam int DW     = G_DWIDTH;
  localparam int PW     = DW + GW + 1;
  localparam int SW     = PW - G_DECIMAL_BITS;
  localparam int RND_SH = (G_DECIMAL_BITS > 0) ? G_DECIMAL_BITS - 1 : 0;
  localparam logic signed [PW-1:0] RND =
    (G_ROUND != 0 && G_DECIMAL_BITS > 0) ? (PW'(1) << RND_SH) : '0;
  localparam logic [CW-1:0] LAST_CH = CW'(G_CHANNELS - 1);

  logic                 w_advance;
  logic                 w_accept;
  logic [CW-1:0]        r_chan;
  logic [GW-1:0]        r_gain;
  logic [GW-1:0]        w_next_gain;
  logic [GW-1:0]        w_diff_up;
  logic [GW-1:0]        w_diff_dn;

  logic                 r_s1_valid;
  logic signed [DW-1:0] r_s1_din;
  logic [CW-1:0]        r_s1_chan;
  logic [GW-1:0]        r_s1_gain;

  logic                 r_s2_valid;
  logic signed [PW-1:0] r_s2_prod;
  logic [CW-1:0]        r_s2_chan;

  logic                 r_dout_valid;
  logic signed [DW-1:0] r_dout;
  logic [CW-1:0]        r_dout_chan;
  logic                 r_dout_last;
  logic                 r_clip;

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;
  logic signed [SW-1:0] w_shift;
  logic                 w_sat;
  logic signed [DW-1:0] w_sat_val;

  assign w_advance = bus.enable & (~r_dout_valid | bus.dout_ready);
  assign w_accept  = w_advance & bus.din_valid;

  // Sample sign-extended, gain zero-extended, both to full product width.
  assign w_a    = PW'(r_s1_din);
  assign w_b    = PW'({1'b0, r_s1_gain});
  assign w_prod = (w_a * w_b) + RND;

  // Dropping the low D bits of a signed value is the arithmetic shift by D.
  assign w_shift = r_s2_prod[PW-1:G_DECIMAL_BITS];
  assign w_sat   = !((&w_shift[SW-1:DW-1]) || (~|w_shift[SW-1:DW-1]));

  // Saturate the shifted product into the output range
  always_comb begin
    w_sat_val = w_shift[DW-1:0];
    if (w_sat) begin
      w_sat_val = w_shift[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  assign w_diff_up = bus.target_gain - r_gain;
  assign w_diff_dn = r_gain - bus.target_gain;

  // Next gain: one step toward target, landing exactly on it when close
  always_comb begin
    w_next_gain = bus.target_gain;
    if (bus.gain_step != '0) begin
      if (bus.target_gain >= r_gain) begin
        if (w_diff_up > bus.gain_step) w_next_gain = r_gain + bus.gain_step;
      end else begin
        if (w_diff_dn > bus.gain_step) w_next_gain = r_gain - bus.gain_step;
      end
    end
  end

  // Pipeline, channel counter, gain ramp and clip flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chan       <= '0;
      r_gain       <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_din     <= '0;
      r_s1_chan    <= '0;
      r_s1_gain    <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_prod    <= '0;
      r_s2_chan    <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_chan  <= '0;
      r_dout_last  <= 1'b0;
      r_clip       <= 1'b0;
    end else begin
      r_clip <= (r_clip & ~bus.clip_clear) | (w_advance & r_s2_valid & w_sat);
      if (!bus.enable) begin
        r_chan       <= '0;
        r_s1_valid   <= 1'b0;
        r_s2_valid   <= 1'b0;
        r_dout_valid <= 1'b0;
      end else if (w_advance) begin
        r_s1_valid <= bus.din_valid;
        if (bus.din_valid) begin
          r_s1_din  <= bus.din;
          r_s1_chan <= r_chan;
          r_s1_gain <= r_gain;
        end
        if (w_accept) begin
          if (r_chan == LAST_CH) begin
            r_chan <= '0;
            r_gain <= w_next_gain;
          end else begin
            r_chan <= r_chan + CW'(1);
          end
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_prod <= w_prod;
          r_s2_chan <= r_s1_chan;
        end
        r_dout_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_dout      <= w_sat_val;
          r_dout_chan <= r_s2_chan;
          r_dout_last <= (r_s2_chan == LAST_CH);
        end
      end
    end
  end

  assign bus.din_ready  = w_advance;
  assign bus.dout       = r_dout;
  assign bus.dout_chan  = r_dout_chan;
  assign bus.dout_last  = r_dout_last;
  assign bus.dout_valid = r_dout_valid;
  assign bus.cur_gain   = r_gain;
  assign bus.clip       = r_clip;
endmodule

// File: tb/tb_gain_ramp_stage.sv
// Scoreboard bench: two instances (rounding and truncating) share stimulus.
module tb_gain_ramp_stage;
  localparam int D  = 16;
  localparam int DW = 24;
  localparam int CH = 2;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 chan;
    logic                 last;
    logic                 sat;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [31:0]          target_gain;
  logic [31:0]          gain_step;
  logic                 clip_clear;
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 dout_ready;

  int     checks = 0;
  int     errors = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  longint m_gain = 0;
  int     m_chan = 0;

  gain_ramp_stage_if #(.G_INTEGER_BITS(16), .G_DECIMAL_BITS(D), .G_DWIDTH(DW), .G_CHANNELS(CH)) ifa();
  gain_ramp_stage_if #(.G_INTEGER_BITS(16), .G_DECIMAL_BITS(D), .G_DWIDTH(DW), .G_CHANNELS(CH)) ifb();

  gain_ramp_stage #(.G_INTEGER_BITS(16), .G_DECIMAL_BITS(D), .G_DWIDTH(DW), .G_CHANNELS(CH), .G_ROUND(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  gain_ramp_stage #(.G_INTEGER_BITS(16), .G_DECIMAL_BITS(D), .G_DWIDTH(DW), .G_CHANNELS(CH), .G_ROUND(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifa.enable = enable;       assign ifb.enable = enable;
  assign ifa.target_gain = target_gain; assign ifb.target_gain = target_gain;
  assign ifa.gain_step = gain_step; assign ifb.gain_step = gain_step;
  assign ifa.clip_clear = clip_clear; assign ifb.clip_clear = clip_clear;
  assign ifa.din = din;             assign ifb.din = din;
  assign ifa.din_valid = din_valid; assign ifb.din_valid = din_valid;
  assign ifa.dout_ready = dout_ready; assign ifb.dout_ready = dout_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: exact product, optional half-LSB bias, floor divide, clamp.
  function automatic exp_t ref_out(input longint d, input longint g, input bit rnd, input int ch);
    exp_t   r;
    longint p;
    p = d * g;
    if (rnd) p = p + (longint'(1) <<< (D - 1));
    p = p >>> D;
    r.sat = 1'b0;
    if (p > MAXV) begin p = MAXV; r.sat = 1'b1; end
    else if (p < MINV) begin p = MINV; r.sat = 1'b1; end
    r.d    = DW'(p);
    r.chan = ch[0];
    r.last = (ch == CH - 1);
    return r;
  endfunction

  function automatic longint next_gain(input longint c, input longint t, input longint s);
    if (s == 0) return t;
    if (t >= c) return (t - c <= s) ? t : c + s;
    return (c - t <= s) ? t : c - s;
  endfunction

  task automatic model_accept(input logic signed [DW-1:0] d);
    qa.push_back(ref_out(longint'(d), m_gain, 1'b1, m_chan));
    qb.push_back(ref_out(longint'(d), m_gain, 1'b0, m_chan));
    if (m_chan == CH - 1) begin
      m_gain = next_gain(m_gain, longint'(target_gain), longint'(gain_step));
      m_chan = 0;
    end else begin
      m_chan++;
    end
  endtask

  // Entered and left at a negedge; holds the beat until accepted.
  task automatic send(input logic signed [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    din = d;
    din_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      #1;
      if (ifa.din_ready) begin
        acc = 1'b1;
        model_accept(d);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_dout_valid", ifa.dout_valid, 0);
    chk("rst_dout", ifa.dout, 0);
    chk("rst_dout_chan", ifa.dout_chan, 0);
    chk("rst_dout_last", ifa.dout_last, 0);
    chk("rst_cur_gain", ifa.cur_gain, 0);
    chk("rst_clip", ifa.clip, 0);
    qa.delete();
    qb.delete();
    m_gain = 0;
    m_chan = 0;
    @(negedge clk);
    reset = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic do_flush();
    enable = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_dout_valid", ifa.dout_valid, 0);
    chk("flush_cur_gain", ifa.cur_gain, m_gain);
    qa.delete();
    qb.delete();
    m_chan = 0;
    @(negedge clk);
    enable = 1'b1;
    dout_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: pop and compare on every output handshake
  always @(negedge clk) begin : mon_a
    exp_t e;
    #2;
    if (ifa.dout_valid && ifa.dout_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_output", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_dout", ifa.dout, e.d);
        chk("a_chan", ifa.dout_chan, e.chan);
        chk("a_last", ifa.dout_last, e.last);
        if (e.sat) chk("a_clip_set", ifa.clip, 1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    #2;
    if (ifb.dout_valid && ifb.dout_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_output", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_dout", ifb.dout, e.d);
        chk("b_chan", ifb.dout_chan, e.chan);
        chk("b_last", ifb.dout_last, e.last);
        if (e.sat) chk("b_clip_set", ifb.clip, 1);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc_n;
    int cyc_n;
    reset = 1'b1; enable = 1'b1; target_gain = '0; gain_step = '0;
    clip_clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Unity gain, latency, channel/last tagging
    target_gain = 32'h0001_0000; gain_step = '0;
    send(0); send(0);
    idle(5);
    send(1000);
    chk("lat_cycle1", ifa.dout_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", ifa.dout_valid, 0);
    @(negedge clk);
    chk("lat_cycle3", ifa.dout_valid, 1);
    send(-1000);
    idle(5);

    // Saturation both ways, sticky clip, clip_clear
    target_gain = 32'h0002_0000;
    send(1000); send(-1000);
    send(24'sh500000); send(24'shB00000);
    idle(6);
    chk("clip_hold_a", ifa.clip, 1);
    chk("clip_hold_b", ifb.clip, 1);
    clip_clear = 1'b1;
    @(negedge clk);
    clip_clear = 1'b0;
    chk("clip_cleared", ifa.clip, 0);

    // Half gain: rounding vs truncation on odd values
    target_gain = 32'h0000_8000;
    send(0); send(0);
    send(-3); send(3);
    idle(6);

    // Ramp from zero to unity in quarter steps
    do_reset();
    target_gain = 32'h0001_0000; gain_step = 32'h0000_4000;
    for (int f = 0; f < 8; f++) begin
      send(4000); send(4000);
    end
    idle(6);
    chk("ramp_final_gain", ifa.cur_gain, m_gain);

    // Partial frame discarded by enable=0
    send(4000);
    do_flush();
    send(-4000); send(4000);
    idle(6);

    // Random traffic with backpressure and target changes
    acc_n = 0;
    cyc_n = 0;
    while (acc_n < 1000 && cyc_n < 20000) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      din        = DW'($urandom);
      dout_ready = ($urandom_range(0, 9) >= 4);
      if ($urandom_range(0, 39) == 0) begin
        target_gain = $urandom_range(0, 32'h0003_0000);
        case ($urandom_range(0, 2))
          0: gain_step = 32'h0;
          1: gain_step = 32'h0000_1000;
          default: gain_step = 32'h0000_8000;
        endcase
      end
      #1;
      if (din_valid && ifa.din_ready) begin
        model_accept(din);
        acc_n++;
      end
      @(negedge clk);
      cyc_n++;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    chk("rand_beats", acc_n, 1000);
    for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
    chk("rand_drain_a", qa.size(), 0);
    chk("rand_drain_b", qb.size(), 0);

    // Reset with three samples in flight
    target_gain = 32'h0001_0000; gain_step = '0;
    send(100); send(200); send(300);
    do_reset();
    send(500);
    idle(6);
    chk("final_queue_a", qa.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
